// File: rtl/window_max_pkg.sv
// Shared types for the window_max streaming reducer: state encoding and
// index-width helper.
package window_max_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } wm_state_t;

   // Position index width; never narrower than one bit.
   function automatic int idx_bits(input int window);
      return (window > 2) ? $clog2(window) : 1;
   endfunction

endpackage

// File: rtl/greater_than.sv
// Unsigned magnitude compare, o = (a > b); purely combinational, zero latency,
// no handshake.
module greater_than #(
   parameter int NUM_BITS = 4
) (
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   output logic                o
);

   assign o = (a > b);

endmodule

// File: rtl/window_max.sv
// Per-window maximum and first-occurrence index over WINDOW accepted samples; result valid the cycle after
// the last sample is accepted. Result is held until out_ready, and input is stalled (in_ready low) meanwhile.
module window_max
   import window_max_pkg::*;
#(
   parameter  int NUM_BITS = 4,
   parameter  int WINDOW   = 8,
   localparam int IDX_BITS = idx_bits(WINDOW)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] out_max,
   output logic [IDX_BITS-1:0] out_index
);

   localparam logic [IDX_BITS-1:0] LAST_POS = IDX_BITS'(WINDOW - 1);

   wm_state_t           r_state;
   logic [IDX_BITS-1:0] r_count;
   logic [IDX_BITS-1:0] r_idx;
   logic [NUM_BITS-1:0] r_max;

   logic w_gt;
   logic w_accept;
   logic w_last;

   greater_than #(
      .NUM_BITS(NUM_BITS)
   ) u_gt (
      .a(in_data),
      .b(r_max),
      .o(w_gt)
   );

   // Decoded from state so an asynchronous reset drops out_valid at once.
   assign in_ready  = (r_state == COLLECT) && !rst;
   assign out_valid = (r_state == HOLD);
   assign out_max   = r_max;
   assign out_index = r_idx;

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_count == LAST_POS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= COLLECT;
         r_count <= '0;
         r_max   <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_accept) begin
                  // Strict compare keeps the earliest position on ties.
                  if (r_count == '0) begin
                     r_max <= in_data;
                     r_idx <= '0;
                  end else if (w_gt) begin
                     r_max <= in_data;
                     r_idx <= r_count;
                  end
                  if (w_last) begin
                     r_count <= '0;
                     r_state <= HOLD;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state <= COLLECT;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_window_max.sv
// Randomised and directed bench for window_max: a reference model queues expected window results,
// and an independent monitor pops and compares them on every result handshake.
module tb_window_max;

   localparam int NUM_BITS = 4;
   localparam int WINDOW   = 8;
   localparam int IDX_BITS = 3;

   typedef struct {
      logic [NUM_BITS-1:0] m;
      logic [IDX_BITS-1:0] ix;
   } res_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [NUM_BITS-1:0] in_data = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [NUM_BITS-1:0] out_max;
   logic [IDX_BITS-1:0] out_index;

   int n_vec = 0;
   int n_err = 0;

   res_t                exp_q[$];
   logic [NUM_BITS-1:0] win[$];
   logic                exp_hold = 1'b0;
   res_t                hold_res;

   window_max #(
      .NUM_BITS(NUM_BITS),
      .WINDOW  (WINDOW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_max  (out_max),
      .out_index(out_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: first position holding the largest value of the window.
   function automatic res_t window_result();
      res_t r;
      r.m  = win[0];
      r.ix = '0;
      for (int i = 1; i < WINDOW; i++) begin
         if (win[i] > r.m) begin
            r.m  = win[i];
            r.ix = IDX_BITS'(i);
         end
      end
      return r;
   endfunction

   task automatic model_clear();
      win.delete();
      exp_q.delete();
      exp_hold = 1'b0;
   endtask

   // One clock cycle: drive inputs, check handshake outputs, advance the model.
   task automatic cycle(input logic v, input logic [NUM_BITS-1:0] d, output logic acc);
      logic xfer;
      in_valid = v;
      in_data  = d;
      @(negedge clk);
      chk("in_ready", in_ready, !exp_hold);
      chk("out_valid", out_valid, exp_hold);
      if (exp_hold) begin
         chk("hold_max", out_max, hold_res.m);
         chk("hold_index", out_index, hold_res.ix);
      end
      acc  = in_valid && !exp_hold;
      xfer = exp_hold && out_ready;
      if (acc) begin
         win.push_back(in_data);
         if (win.size() == WINDOW) begin
            hold_res = window_result();
            exp_q.push_back(hold_res);
            win.delete();
            exp_hold = 1'b1;
         end
      end
      if (xfer) exp_hold = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [NUM_BITS-1:0] d);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
         cycle(1'b1, d, acc);
         tries++;
      end
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: sample %0d not accepted within %0d cycles", d, tries);
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
   endtask

   task automatic reset_cycles(input int n);
      rst      = 1'b1;
      in_valid = 1'b0;
      model_clear();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_in_ready", in_ready, 1'b0);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_max", out_max, '0);
         chk("rst_out_index", out_index, '0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // Scoreboard monitor: consumes one expected result per result handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result at %0t: max %0d index %0d, none expected", $time, out_max, out_index);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("result_max", out_max, e.m);
            chk("result_index", out_index, e.ix);
         end
      end
   end

   initial begin
      logic [NUM_BITS-1:0] s2[8];
      logic [NUM_BITS-1:0] s4[8];
      logic [NUM_BITS-1:0] s5[8];
      logic                acc;
      s2 = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd2, 4'd15, 4'd0, 4'd7};
      s4 = '{4'd5, 4'd4, 4'd12, 4'd12, 4'd0, 4'd1, 4'd2, 4'd3};
      s5 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6};

      #1;
      reset_cycles(3);

      // Basic window with a later tie at the maximum.
      out_ready = 1'b1;
      foreach (s2[i]) send(s2[i]);
      idle(2);

      // All-equal window, then a rising window.
      for (int i = 0; i < WINDOW; i++) send(4'd0);
      for (int i = 1; i <= WINDOW; i++) send(NUM_BITS'(i));
      idle(2);

      // Input gaps, then output backpressure with in_valid held high.
      out_ready = 1'b0;
      foreach (s4[i]) begin
         idle(1 + (i % 2));
         send(s4[i]);
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 4'd15, acc);
      out_ready = 1'b1;
      cycle(1'b0, '0, acc);
      out_ready = 1'b0;
      idle(1);

      // Reset mid-window discards the partial window.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(4'd15);
      reset_cycles(1);
      foreach (s5[i]) send(s5[i]);
      idle(2);

      // Reset while a result is held: out_valid must fall without a clock edge.
      out_ready = 1'b0;
      for (int i = 0; i < WINDOW; i++) send(NUM_BITS'($urandom_range(0, 15)));
      chk("hold_before_rst", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 1'b0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      foreach (s2[i]) send(s2[i]);
      idle(2);

      // Random traffic with random backpressure and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         logic [NUM_BITS-1:0] d;
         out_ready = ($urandom_range(0, 3) != 0);
         d = (c < 750) ? NUM_BITS'($urandom_range(0, 3)) : NUM_BITS'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            reset_cycles(1);
         end else begin
            cycle($urandom_range(0, 3) != 0, d, acc);
         end
      end

      out_ready = 1'b1;
      idle(4);
      chk("results_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
